// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation
// encodings, latency constants and the commit-action type used between
// acceptance and the end of the busy window.
package mdu_pkg;

   // MDU operation codes as presented on the op port
   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8,
      MDU_MADD  = 4'd9,
      MDU_MADDU = 4'd10
   } mdu_op_e;

   // Busy-window lengths in cycles
   localparam int MDU_MULT_LAT = 5;
   localparam int MDU_DIV_LAT  = 10;

   // Down-counter width, large enough for the longest latency
   localparam int MDU_CNT_W = 4;

   // What happens to HI/LO when the busy window closes
   typedef enum logic [1:0] {
      PEND_NONE = 2'd0,   // nothing to write (divide by zero)
      PEND_LOAD = 2'd1,   // overwrite HI/LO with the pending pair
      PEND_ACC  = 2'd2    // add the pending product into HI/LO
   } pend_kind_e;

   // Counter preset for a given latency
   function automatic logic [MDU_CNT_W-1:0] lat_preset(input int lat);
      return MDU_CNT_W'(lat);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core of the MDU: 64-bit product and
// quotient/remainder of two 32-bit operands, signed or unsigned, plus a
// divide-by-zero flag. Holds no state; sequencing lives in ex_mdu.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sign_en,
   output logic [63:0] product,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_zero
);

   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_safe;
   logic [31:0] q_mag;
   logic [31:0] r_mag;

   // Multiply: the low 64 bits of a product of sign- (or zero-) extended
   // operands are the exact two's-complement result in both modes
   always_comb begin
      a_ext   = {{32{sign_en & a[31]}}, a};
      b_ext   = {{32{sign_en & b[31]}}, b};
      product = a_ext * b_ext;
   end

   // Divide on magnitudes, then restore signs: quotient negative when the
   // operand signs differ, remainder takes the dividend's sign. The
   // magnitude of 0x80000000 is itself as an unsigned value, so the
   // 0x80000000 / -1 overflow case wraps to 0x80000000 with remainder 0.
   always_comb begin
      a_neg     = sign_en & a[31];
      b_neg     = sign_en & b[31];
      a_mag     = a_neg ? (~a + 32'd1) : a;
      b_mag     = b_neg ? (~b + 32'd1) : b;
      div_zero  = (b == 32'd0);
      // keep the divider well defined; the result is discarded anyway
      b_safe    = div_zero ? 32'd1 : b_mag;
      q_mag     = a_mag / b_safe;
      r_mag     = a_mag % b_safe;
      quotient  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      remainder = a_neg ? (~r_mag + 32'd1) : r_mag;
   end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit. Multi-cycle ops compute their result at
// acceptance into pending registers, hold busy for a fixed latency via a
// down-counter, and commit into HI/LO as busy drops. MTHI/MTLO write in a
// single cycle; MFHI/MFLO read HI/LO combinationally.
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU accumulate.
module ex_mdu
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] E_MDU_Result,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   // Architectural and pending state
   logic [31:0]          hi_reg;
   logic [31:0]          lo_reg;
   logic [31:0]          pend_hi_reg;
   logic [31:0]          pend_lo_reg;
   pend_kind_e           pend_kind_reg;
   logic [MDU_CNT_W-1:0] cnt_reg;

   // Decode
   logic is_mul;
   logic is_div;
   logic is_madd;
   logic is_mthi;
   logic is_mtlo;
   logic sign_en;
   logic accept;
   logic commit;

   // Arithmetic results
   logic [63:0] product;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_zero;
   logic [63:0] acc_sum;

   mdu_arith u_arith (
      .a         (A),
      .b         (B),
      .sign_en   (sign_en),
      .product   (product),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   // Classify op; unlisted codes (and MADD/MADDU when disabled) are NONE
   always_comb begin
      is_mul  = 1'b0;
      is_div  = 1'b0;
      is_madd = 1'b0;
      is_mthi = 1'b0;
      is_mtlo = 1'b0;
      sign_en = 1'b0;
      case (op)
         MDU_MULT:  begin is_mul = 1'b1; sign_en = 1'b1; end
         MDU_MULTU: is_mul = 1'b1;
         MDU_DIV:   begin is_div = 1'b1; sign_en = 1'b1; end
         MDU_DIVU:  is_div = 1'b1;
         MDU_MTHI:  is_mthi = 1'b1;
         MDU_MTLO:  is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
         MDU_MADD:  begin is_madd = 1'b1; sign_en = 1'b1; end
         MDU_MADDU: is_madd = 1'b1;
`endif
         default:   ;
      endcase
   end

   assign busy   = (cnt_reg != '0);
   assign accept = start & ~busy;
   // last busy cycle: the counter reaches zero at this edge
   assign commit = (cnt_reg == MDU_CNT_W'(1));

`ifdef MDU_MADD_EN
   // accumulate uses HI/LO as they stand at the commit edge
   assign acc_sum = {hi_reg, lo_reg} + {pend_hi_reg, pend_lo_reg};
`else
   assign acc_sum = {pend_hi_reg, pend_lo_reg};
`endif

   // Busy down-counter: preset on acceptance, counts to zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (busy) begin
         cnt_reg <= cnt_reg - MDU_CNT_W'(1);
      end else if (accept && (is_mul || is_madd)) begin
         cnt_reg <= lat_preset(MDU_MULT_LAT);
      end else if (accept && is_div) begin
         cnt_reg <= lat_preset(MDU_DIV_LAT);
      end
   end

   // Capture the operation result and its commit action at acceptance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_hi_reg   <= '0;
         pend_lo_reg   <= '0;
         pend_kind_reg <= PEND_NONE;
      end else if (accept && (is_mul || is_madd)) begin
         pend_hi_reg   <= product[63:32];
         pend_lo_reg   <= product[31:0];
         pend_kind_reg <= is_madd ? PEND_ACC : PEND_LOAD;
      end else if (accept && is_div) begin
         pend_hi_reg   <= remainder;
         pend_lo_reg   <= quotient;
         pend_kind_reg <= div_zero ? PEND_NONE : PEND_LOAD;
      end
   end

   // HI/LO update: commit at the end of busy wins over a direct move
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_reg <= '0;
         lo_reg <= '0;
      end else if (commit) begin
         case (pend_kind_reg)
            PEND_LOAD: begin
               hi_reg <= pend_hi_reg;
               lo_reg <= pend_lo_reg;
            end
            PEND_ACC: begin
               hi_reg <= acc_sum[63:32];
               lo_reg <= acc_sum[31:0];
            end
            default: ;
         endcase
      end else if (accept && is_mthi) begin
         hi_reg <= A;
      end else if (accept && is_mtlo) begin
         lo_reg <= A;
      end
   end

   // Move-from read path: current HI/LO only, never the pending pair
   always_comb begin
      E_MDU_Result = '0;
      if (!reset) begin
         case (op)
            MDU_MFHI: E_MDU_Result = hi_reg;
            MDU_MFLO: E_MDU_Result = lo_reg;
            default:  ;
         endcase
      end
   end

   assign HI = hi_reg;
   assign LO = lo_reg;

endmodule
